multdiv_scheduler: RTL and testbench

MULTDIV_SCHEDULER -- requirements
Module: multdiv_scheduler

---
 rtl/md_sched_pkg.sv | 20 ++
 rtl/md_hazard_check.sv | 13 +
 rtl/multdiv_scheduler.sv | 145 ++++++++++++++
 tb/tb_multdiv_scheduler.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_sched_pkg.sv
// Shared encodings for the multiply/divide scheduler.
package md_sched_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StRun   = 2'd2,
    StDone  = 2'd3
  } md_state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } md_op_e;

  localparam int unsigned DEFAULT_STATUS_REG  = 30;
  localparam int unsigned DEFAULT_MULT_STATUS = 4;
  localparam int unsigned DEFAULT_DIV_STATUS  = 5;

endpackage

// File: rtl/md_hazard_check.sv
// Compares FD-stage source registers against the in-flight destination; r0 never matches.
module md_hazard_check (
  input  logic [4:0] src_a,
  input  logic [4:0] src_b,
  input  logic [4:0] rd,
  output logic       match
);

  always_comb begin
    match = ((src_a == rd) && (src_a != 5'd0)) || ((src_b == rd) && (src_b != 5'd0));
  end

endmodule

// File: rtl/multdiv_scheduler.sv
// Issues one mult/div at a time and arbitrates its result onto the regfile write port.
// Define MULTDIV_EXCEPTION_EN to redirect exceptions to the status register.
module multdiv_scheduler
  import md_sched_pkg::*;
#(
  parameter int unsigned STATUS_REG  = DEFAULT_STATUS_REG,
  parameter int unsigned MULT_STATUS = DEFAULT_MULT_STATUS,
  parameter int unsigned DIV_STATUS  = DEFAULT_DIV_STATUS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_op,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  input  logic [4:0]  src_a,
  input  logic [4:0]  src_b,
  output logic        hazard_stall,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  input  logic        pipe_we,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        busy
);

  md_state_e   state_q, state_d;
  md_op_e      op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] result_q, result_d;
  logic        wr_needed;
  logic        reg_match;

`ifdef MULTDIV_EXCEPTION_EN
  logic exc_q, exc_d;
`else
  logic unused_md_exception;
  assign unused_md_exception = md_exception;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      op_q     <= OP_MULT;
      rd_q     <= 5'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

`ifdef MULTDIV_EXCEPTION_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      exc_q <= 1'b0;
    end else begin
      exc_q <= exc_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
`ifdef MULTDIV_EXCEPTION_EN
    exc_d    = exc_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (issue_valid) begin
          op_d    = md_op_e'(issue_op);
          rd_d    = issue_rd;
          a_d     = issue_a;
          b_d     = issue_b;
          state_d = StStart;
        end
      end
      StStart: state_d = StRun;
      StRun: begin
        if (md_ready) begin
          result_d = md_result;
`ifdef MULTDIV_EXCEPTION_EN
          exc_d    = md_exception;
`endif
          state_d  = StDone;
        end
      end
      // Leave on any cycle the port is free, even when nothing needs writing (rd == 0).
      StDone: begin
        if (!pipe_we) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  md_hazard_check u_hazard (
    .src_a (src_a),
    .src_b (src_b),
    .rd    (rd_q),
    .match (reg_match)
  );

  always_comb begin
    issue_ready  = (state_q == StIdle);
    busy         = (state_q != StIdle);
    hazard_stall = (busy && reg_match) || (issue_valid && !issue_ready);
    md_a         = a_q;
    md_b         = b_q;
    ctrl_MULT    = (state_q == StStart) && (op_q == OP_MULT);
    ctrl_DIV     = (state_q == StStart) && (op_q == OP_DIV);
`ifdef MULTDIV_EXCEPTION_EN
    wr_needed    = exc_q || (rd_q != 5'd0);
    wb_reg       = exc_q ? 5'(STATUS_REG) : rd_q;
    wb_data      = !exc_q ? result_q :
                   (op_q == OP_DIV) ? 32'(DIV_STATUS) : 32'(MULT_STATUS);
`else
    wr_needed    = (rd_q != 5'd0);
    wb_reg       = rd_q;
    wb_data      = result_q;
`endif
    wb_valid     = (state_q == StDone) && !pipe_we && wr_needed;
  end

endmodule

// File: tb/tb_multdiv_scheduler.sv
// Directed self-checking bench for multdiv_scheduler; the bench acts as the multdiv unit.
module tb_multdiv_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid, issue_op;
  logic [31:0] issue_a, issue_b;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  src_a, src_b;
  logic        hazard_stall;
  logic [31:0] md_a, md_b;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception, md_ready;
  logic        pipe_we;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_mult   = 0;
  int n_div    = 0;
  int n_overlap = 0;
  int m0;

  multdiv_scheduler dut (
    .clock        (clock),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_op     (issue_op),
    .issue_a      (issue_a),
    .issue_b      (issue_b),
    .issue_rd     (issue_rd),
    .issue_ready  (issue_ready),
    .src_a        (src_a),
    .src_b        (src_b),
    .hazard_stall (hazard_stall),
    .md_a         (md_a),
    .md_b         (md_b),
    .ctrl_MULT    (ctrl_MULT),
    .ctrl_DIV     (ctrl_DIV),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_ready     (md_ready),
    .pipe_we      (pipe_we),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ctrl_MULT) n_mult <= n_mult + 1;
    if (ctrl_DIV) n_div <= n_div + 1;
    if (ctrl_MULT && ctrl_DIV) n_overlap <= n_overlap + 1;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_a     = a;
    issue_b     = b;
    issue_rd    = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    issue_valid = 1'b0; issue_op = 1'b0; issue_a = '0; issue_b = '0; issue_rd = '0;
    src_a = '0; src_b = '0; md_result = '0; md_exception = 1'b0; md_ready = 1'b0;
    pipe_we = 1'b0;
    step();
    step();
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(issue_ready), 32'd1);
    chk("rst_md_a", md_a, 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_ctrl", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd0);
    reset = 1'b1;

    // Mult 7*6 rd=5; md_ready ignored in IDLE and START
    md_ready = 1'b1; md_result = 32'd99;
    step(); #1;
    chk("idle_ignore_ready", 32'(busy), 32'd0);
    md_ready = 1'b0;
    issue(1'b0, 32'd7, 32'd6, 5'd5);
    #1;
    chk("s1_ready", 32'(issue_ready), 32'd1);
    chk("s1_nostall", 32'(hazard_stall), 32'd0);
    m0 = n_mult;
    step();
    issue_valid = 1'b0; md_ready = 1'b1; md_result = 32'd99;
    #1;
    chk("s1_ctrl", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd2);
    chk("s1_md_a", md_a, 32'd7);
    chk("s1_md_b", md_b, 32'd6);
    step();
    md_ready = 1'b0;
    #1;
    chk("s1_pulse_end", 32'(ctrl_MULT), 32'd0);
    chk("s1_start_ignore", 32'(wb_valid), 32'd0);
    step(); #1;
    chk("s1_run_wait", 32'(wb_valid), 32'd0);
    md_ready = 1'b1; md_result = 32'd42;
    step();
    md_ready = 1'b0;
    #1;
    chk("s1_wb_valid", 32'(wb_valid), 32'd1);
    chk("s1_wb_reg", 32'(wb_reg), 32'd5);
    chk("s1_wb_data", wb_data, 32'd42);
    chk("s1_md_a_hold", md_a, 32'd7);
    step(); #1;
    chk("s1_idle", 32'(busy), 32'd0);
    chk("s1_wb_off", 32'(wb_valid), 32'd0);
    chk("s1_one_pulse", 32'(n_mult - m0), 32'd1);

    // Div 100/7 rd=9, src_a=9, pipeline owns the port for 4 cycles
    issue(1'b1, 32'd100, 32'd7, 5'd9);
    src_a = 5'd9;
    step();
    issue_valid = 1'b0;
    #1;
    chk("s2_ctrl", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd1);
    chk("s2_stall_start", 32'(hazard_stall), 32'd1);
    step();
    md_ready = 1'b1; md_result = 32'd14;
    #1;
    chk("s2_stall_run", 32'(hazard_stall), 32'd1);
    step();
    md_ready = 1'b0; pipe_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      #1;
      chk("s2_pipe_prio", 32'(wb_valid), 32'd0);
    end
    step();
    pipe_we = 1'b0;
    #1;
    chk("s2_wb_valid", 32'(wb_valid), 32'd1);
    chk("s2_wb_reg", 32'(wb_reg), 32'd9);
    chk("s2_wb_data", wb_data, 32'd14);
    chk("s2_stall_write", 32'(hazard_stall), 32'd1);
    step(); #1;
    chk("s2_idle", 32'(busy), 32'd0);
    chk("s2_stall_clear", 32'(hazard_stall), 32'd0);
    chk("s2_wb_once", 32'(wb_valid), 32'd0);
    src_a = 5'd0;

    // rd=0, src_b=0: never stalls, never writes
    issue(1'b0, 32'd3, 32'd3, 5'd0);
    step();
    issue_valid = 1'b0;
    #1;
    chk("s3_stall_start", 32'(hazard_stall), 32'd0);
    step();
    md_ready = 1'b1; md_result = 32'd9;
    #1;
    chk("s3_stall_run", 32'(hazard_stall), 32'd0);
    step();
    md_ready = 1'b0;
    #1;
    chk("s3_no_write", 32'(wb_valid), 32'd0);
    chk("s3_done_busy", 32'(busy), 32'd1);
    step(); #1;
    chk("s3_idle", 32'(busy), 32'd0);

    // Div by 0 with exception flag
    issue(1'b1, 32'd50, 32'd0, 5'd12);
    step();
    issue_valid = 1'b0;
    step();
    md_ready = 1'b1; md_exception = 1'b1; md_result = 32'hFFFF_FFFF;
    step();
    md_ready = 1'b0; md_exception = 1'b0;
    #1;
    chk("s4_wb_valid", 32'(wb_valid), 32'd1);
`ifdef MULTDIV_EXCEPTION_EN
    chk("s4_wb_reg", 32'(wb_reg), 32'd30);
    chk("s4_wb_data", wb_data, 32'd5);
`else
    chk("s4_wb_reg", 32'(wb_reg), 32'd12);
    chk("s4_wb_data", wb_data, 32'hFFFF_FFFF);
`endif
    step();

    // Reset during RUN, then a late md_ready
    issue(1'b0, 32'd8, 32'd8, 5'd7);
    step();
    issue_valid = 1'b0;
    step();
    #1;
    reset = 1'b0;
    #1;
    chk("s5_rst_busy", 32'(busy), 32'd0);
    chk("s5_rst_md_a", md_a, 32'd0);
    chk("s5_rst_wb_reg", 32'(wb_reg), 32'd0);
    step();
    reset = 1'b1; md_ready = 1'b1; md_result = 32'd55;
    #1;
    chk("s5_late_busy", 32'(busy), 32'd0);
    step();
    md_ready = 1'b0;
    #1;
    chk("s5_late_no_wb", 32'(wb_valid), 32'd0);
    chk("s5_late_idle", 32'(busy), 32'd0);
    issue(1'b0, 32'd3, 32'd4, 5'd8);
    step();
    issue_valid = 1'b0;
    #1;
    chk("s5_re_ctrl", 32'(ctrl_MULT), 32'd1);
    chk("s5_re_md_a", md_a, 32'd3);
    step();
    md_ready = 1'b1; md_result = 32'd12;
    step();
    md_ready = 1'b0;
    #1;
    chk("s5_re_wb_reg", 32'(wb_reg), 32'd8);
    chk("s5_re_wb_data", wb_data, 32'd12);
    step();

    // issue_valid arriving in DONE is held off for one cycle
    issue(1'b1, 32'd20, 32'd4, 5'd2);
    step();
    issue_valid = 1'b0;
    step();
    md_ready = 1'b1; md_result = 32'd5;
    step();
    md_ready = 1'b0;
    issue(1'b0, 32'd5, 32'd5, 5'd3);
    #1;
    chk("s6_stall", 32'(hazard_stall), 32'd1);
    chk("s6_not_ready", 32'(issue_ready), 32'd0);
    chk("s6_wb_valid", 32'(wb_valid), 32'd1);
    chk("s6_wb_data", wb_data, 32'd5);
    step(); #1;
    chk("s6_idle_ready", 32'(issue_ready), 32'd1);
    chk("s6_idle_nostall", 32'(hazard_stall), 32'd0);
    chk("s6_idle_noctrl", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd0);
    step();
    issue_valid = 1'b0;
    #1;
    chk("s6_ctrl", 32'(ctrl_MULT), 32'd1);
    chk("s6_md_a", md_a, 32'd5);
    step();
    md_ready = 1'b1; md_result = 32'd25;
    step();
    md_ready = 1'b0;
    #1;
    chk("s6_wb_reg", 32'(wb_reg), 32'd3);
    chk("s6_wb_data2", wb_data, 32'd25);
    step(); #1;

    chk("mult_pulses", 32'(n_mult), 32'd5);
    chk("div_pulses", 32'(n_div), 32'd3);
    chk("no_overlap", 32'(n_overlap), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
